lsu_agu: RTL and testbench

Address-generation and alignment stage directly upstream of the LSU control unit. It accepts load/store micro-ops from dispatch and computes the effective address `rs1 + imm`. It issues a word-aligned DTCM command (address, replicated write data, byte mask, itag) into the LSU-ctrl AGU interface. It tracks the single outstanding transaction so that it can extract and sign- or zero-extend load data when the response returns.

---
 rtl/lsu_agu_if.sv | 62 ++++++
 rtl/lsu_agu.sv | 205 ++++++++++++++++++++
 tb/tb_lsu_agu.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_agu_if.sv
// Dispatch, LSU-ctrl command/response and exception-handshake signals of lsu_agu.
// slave = the AGU itself, master = its environment (dispatch / LSU-ctrl / trap logic).
interface lsu_agu_if #(
   parameter int unsigned XLEN   = 32,
   parameter int unsigned AW     = 16,
   parameter int unsigned ITAG_W = 1
);
   logic                  agu_i_valid;
   logic                  agu_i_ready;
   logic                  agu_i_read;
   logic [1:0]            agu_i_size;
   logic                  agu_i_usign;
   logic [XLEN-1:0]       agu_i_rs1;
   logic [XLEN-1:0]       agu_i_imm;
   logic [XLEN-1:0]       agu_i_rs2;
   logic [ITAG_W-1:0]     agu_i_itag;

   logic                  agu_cmd_valid;
   logic                  agu_cmd_ready;
   logic                  agu_cmd_read;
   logic [AW-1:0]         agu_cmd_addr;
   logic [XLEN-1:0]       agu_cmd_wdata;
   logic [XLEN/8-1:0]     agu_cmd_wmask;
   logic [ITAG_W-1:0]     agu_cmd_itag;

   logic                  agu_rsp_valid;
   logic                  agu_rsp_ready;
   logic [XLEN-1:0]       agu_rsp_rdata;
   logic [XLEN-1:0]       agu_o_ldata;

   logic                  agu_o_excp_valid;
   logic                  agu_o_excp_ready;
   logic [XLEN-1:0]       agu_o_excp_addr;
   logic [ITAG_W-1:0]     agu_o_excp_itag;
   logic                  agu_o_excp_store;

   modport slave (
      input  agu_i_valid, agu_i_read, agu_i_size, agu_i_usign,
             agu_i_rs1, agu_i_imm, agu_i_rs2, agu_i_itag,
      output agu_i_ready,
      output agu_cmd_valid, agu_cmd_read, agu_cmd_addr, agu_cmd_wdata,
             agu_cmd_wmask, agu_cmd_itag,
      input  agu_cmd_ready,
      input  agu_rsp_valid, agu_rsp_rdata,
      output agu_rsp_ready, agu_o_ldata,
      output agu_o_excp_valid, agu_o_excp_addr, agu_o_excp_itag, agu_o_excp_store,
      input  agu_o_excp_ready
   );

   modport master (
      output agu_i_valid, agu_i_read, agu_i_size, agu_i_usign,
             agu_i_rs1, agu_i_imm, agu_i_rs2, agu_i_itag,
      input  agu_i_ready,
      input  agu_cmd_valid, agu_cmd_read, agu_cmd_addr, agu_cmd_wdata,
             agu_cmd_wmask, agu_cmd_itag,
      output agu_cmd_ready,
      output agu_rsp_valid, agu_rsp_rdata,
      input  agu_rsp_ready, agu_o_ldata,
      input  agu_o_excp_valid, agu_o_excp_addr, agu_o_excp_itag, agu_o_excp_store,
      output agu_o_excp_ready
   );
endinterface

// File: rtl/lsu_agu.sv
// lsu_agu: effective-address generation, word-aligned DTCM command issue and load extraction.
// Define AGU_MISALIGN_EXCP_EN to trap misaligned half/word ops instead of issuing them.
module lsu_agu #(
   parameter int unsigned XLEN   = 32,
   parameter int unsigned AW     = 16,
   parameter int unsigned ITAG_W = 1
) (
   input  logic     clk,
   input  logic     rst,
   lsu_agu_if.slave agu
);
   localparam int unsigned NB = XLEN / 8;

`ifdef AGU_MISALIGN_EXCP_EN
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_PEND = 2'd1, S_EXCP = 2'd2} state_e;
`else
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_PEND = 2'd1} state_e;
`endif

   state_e          state_q, state_d;

   logic [XLEN-1:0] ea;
   logic [1:0]      off;
   logic [1:0]      lane;
   logic            is_byte;
   logic            is_half;
   logic            misalign;
   logic [XLEN-1:0] st_wdata;
   logic [NB-1:0]   st_wmask;

   logic            cmd_valid;
   logic            i_ready;
   logic            cmd_fire;

   logic            cap_read_q,  cap_read_d;
   logic [1:0]      cap_size_q,  cap_size_d;
   logic            cap_usign_q, cap_usign_d;
   logic [1:0]      cap_lane_q,  cap_lane_d;

   logic [XLEN-1:0] shifted;
   logic [XLEN-1:0] ldata;

   always_comb begin
      ea       = agu.agu_i_rs1 + agu.agu_i_imm;
      off      = ea[1:0];
      is_byte  = (agu.agu_i_size == 2'b00);
      is_half  = (agu.agu_i_size == 2'b01);
      lane     = 2'b00;
      st_wdata = agu.agu_i_rs2;
      st_wmask = '1;
      if (is_byte) begin
         lane     = off;
         st_wdata = {NB{agu.agu_i_rs2[7:0]}};
         st_wmask = NB'(1) << lane;
      end else if (is_half) begin
         lane     = {off[1], 1'b0};
         st_wdata = {(NB/2){agu.agu_i_rs2[15:0]}};
         st_wmask = NB'(3) << lane;
      end
   end

`ifdef AGU_MISALIGN_EXCP_EN
   assign misalign = (is_half & off[0]) | (~is_byte & ~is_half & (off != 2'b00));
`else
   assign misalign = 1'b0;
`endif

   assign agu.agu_cmd_valid = cmd_valid;
   assign agu.agu_i_ready   = i_ready;
   assign agu.agu_cmd_read  = agu.agu_i_read;
   assign agu.agu_cmd_addr  = {ea[AW-1:2], 2'b00};
   assign agu.agu_cmd_wdata = agu.agu_i_read ? '0 : st_wdata;
   assign agu.agu_cmd_wmask = agu.agu_i_read ? '0 : st_wmask;
   assign agu.agu_cmd_itag  = agu.agu_i_itag;
   assign agu.agu_rsp_ready = 1'b1;
   assign agu.agu_o_ldata   = ldata;

`ifdef AGU_MISALIGN_EXCP_EN
   logic              exc_fire;
   logic [XLEN-1:0]   excp_addr_q,  excp_addr_d;
   logic [ITAG_W-1:0] excp_itag_q,  excp_itag_d;
   logic              excp_store_q, excp_store_d;
`endif

   // PEND accepts a new op only alongside the response, giving one op per cycle
   always_comb begin
      state_d   = state_q;
      cmd_valid = 1'b0;
      i_ready   = 1'b0;
      case (state_q)
         S_IDLE: begin
            cmd_valid = agu.agu_i_valid & ~misalign;
            i_ready   = agu.agu_cmd_ready | misalign;
         end
         S_PEND: begin
            cmd_valid = agu.agu_i_valid & ~misalign & agu.agu_rsp_valid;
            i_ready   = agu.agu_rsp_valid & (agu.agu_cmd_ready | misalign);
         end
`ifdef AGU_MISALIGN_EXCP_EN
         S_EXCP: begin
            if (agu.agu_o_excp_ready) state_d = S_IDLE;
         end
`endif
         default: state_d = S_IDLE;
      endcase
      if (rst) begin
         cmd_valid = 1'b0;
         i_ready   = 1'b0;
      end
      cmd_fire = cmd_valid & agu.agu_cmd_ready;
`ifdef AGU_MISALIGN_EXCP_EN
      exc_fire = agu.agu_i_valid & i_ready & misalign;
`endif
      if (cmd_fire) begin
         state_d = S_PEND;
`ifdef AGU_MISALIGN_EXCP_EN
      end else if (exc_fire) begin
         state_d = S_EXCP;
`endif
      end else if (state_q == S_PEND && agu.agu_rsp_valid) begin
         state_d = S_IDLE;
      end
   end

   always_comb begin
      cap_read_d  = cap_read_q;
      cap_size_d  = cap_size_q;
      cap_usign_d = cap_usign_q;
      cap_lane_d  = cap_lane_q;
      if (cmd_fire) begin
         cap_read_d  = agu.agu_i_read;
         cap_size_d  = agu.agu_i_size;
         cap_usign_d = agu.agu_i_usign;
         cap_lane_d  = lane;
      end
   end

   always_comb begin
      shifted = agu.agu_rsp_rdata >> {cap_lane_q, 3'b000};
      ldata   = '0;
      if (state_q == S_PEND && agu.agu_rsp_valid && cap_read_q) begin
         case (cap_size_q)
            2'b00:   ldata = cap_usign_q ? XLEN'(shifted[7:0])
                                         : {{(XLEN-8){shifted[7]}}, shifted[7:0]};
            2'b01:   ldata = cap_usign_q ? XLEN'(shifted[15:0])
                                         : {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            default: ldata = shifted;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cap_read_q  <= 1'b0;
         cap_size_q  <= 2'b00;
         cap_usign_q <= 1'b0;
         cap_lane_q  <= 2'b00;
      end else begin
         state_q     <= state_d;
         cap_read_q  <= cap_read_d;
         cap_size_q  <= cap_size_d;
         cap_usign_q <= cap_usign_d;
         cap_lane_q  <= cap_lane_d;
      end
   end

`ifdef AGU_MISALIGN_EXCP_EN
   always_comb begin
      excp_addr_d  = excp_addr_q;
      excp_itag_d  = excp_itag_q;
      excp_store_d = excp_store_q;
      if (exc_fire) begin
         excp_addr_d  = ea;
         excp_itag_d  = agu.agu_i_itag;
         excp_store_d = ~agu.agu_i_read;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         excp_addr_q  <= '0;
         excp_itag_q  <= '0;
         excp_store_q <= 1'b0;
      end else begin
         excp_addr_q  <= excp_addr_d;
         excp_itag_q  <= excp_itag_d;
         excp_store_q <= excp_store_d;
      end
   end

   assign agu.agu_o_excp_valid = (state_q == S_EXCP);
   assign agu.agu_o_excp_addr  = (state_q == S_EXCP) ? excp_addr_q : '0;
   assign agu.agu_o_excp_itag  = (state_q == S_EXCP) ? excp_itag_q : '0;
   assign agu.agu_o_excp_store = (state_q == S_EXCP) & excp_store_q;
`else
   logic unused_excp;
   assign unused_excp = &{1'b0, agu.agu_o_excp_ready, ea[XLEN-1:AW]};

   assign agu.agu_o_excp_valid = 1'b0;
   assign agu.agu_o_excp_addr  = '0;
   assign agu.agu_o_excp_itag  = '0;
   assign agu.agu_o_excp_store = 1'b0;
`endif
endmodule

// File: tb/tb_lsu_agu.sv
// Scoreboard bench for lsu_agu: directed ops push expected commands/load data/exceptions,
// a negedge monitor pops and compares whenever the DUT presents them.
module tb_lsu_agu;
   localparam int unsigned XLEN   = 32;
   localparam int unsigned AW     = 16;
   localparam int unsigned ITAG_W = 1;

   typedef struct {
      logic              read;
      logic [AW-1:0]     addr;
      logic [XLEN-1:0]   wdata;
      logic [XLEN/8-1:0] wmask;
      logic [ITAG_W-1:0] itag;
   } cmd_t;

   typedef struct {
      logic [XLEN-1:0]   addr;
      logic [ITAG_W-1:0] itag;
      logic              store;
   } exc_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   lsu_agu_if #(.XLEN(XLEN), .AW(AW), .ITAG_W(ITAG_W)) bus ();

   lsu_agu #(.XLEN(XLEN), .AW(AW), .ITAG_W(ITAG_W)) dut (
      .clk (clk),
      .rst (rst),
      .agu (bus)
   );

   int unsigned n_vec  = 0;
   int unsigned n_miss = 0;

   cmd_t            cq[$];
   logic [XLEN-1:0] lq[$];
   exc_t            xq[$];

   cmd_t            ce;
   exc_t            xe;
   logic [XLEN-1:0] le;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
      n_vec++;
      if (act !== expv) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, expv, $time);
      end
   endtask

   task automatic unexpected(input string name, input logic [63:0] act);
      n_vec++;
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected nothing (t=%0t)", name, act, $time);
   endtask

   always @(negedge clk) begin
      if (bus.agu_cmd_valid && bus.agu_cmd_ready) begin
         if (cq.size() == 0) unexpected("cmd_unexpected", 64'(bus.agu_cmd_addr));
         else begin
            ce = cq.pop_front();
            chk("cmd_read",  64'(bus.agu_cmd_read),  64'(ce.read));
            chk("cmd_addr",  64'(bus.agu_cmd_addr),  64'(ce.addr));
            chk("cmd_wdata", 64'(bus.agu_cmd_wdata), 64'(ce.wdata));
            chk("cmd_wmask", 64'(bus.agu_cmd_wmask), 64'(ce.wmask));
            chk("cmd_itag",  64'(bus.agu_cmd_itag),  64'(ce.itag));
         end
      end
      if (bus.agu_rsp_valid) begin
         if (lq.size() == 0) unexpected("ldata_unexpected", 64'(bus.agu_o_ldata));
         else begin
            le = lq.pop_front();
            chk("ldata", 64'(bus.agu_o_ldata), 64'(le));
         end
      end
      if (bus.agu_o_excp_valid) begin
         if (xq.size() == 0) unexpected("excp_unexpected", 64'(bus.agu_o_excp_addr));
         else begin
            xe = xq[0];
            chk("excp_addr",  64'(bus.agu_o_excp_addr),  64'(xe.addr));
            chk("excp_itag",  64'(bus.agu_o_excp_itag),  64'(xe.itag));
            chk("excp_store", 64'(bus.agu_o_excp_store), 64'(xe.store));
            if (bus.agu_o_excp_ready) void'(xq.pop_front());
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic op(input logic rd, input logic [1:0] sz, input logic us,
                     input logic [XLEN-1:0] r1, input logic [XLEN-1:0] im,
                     input logic [XLEN-1:0] r2, input logic [ITAG_W-1:0] tg);
      bus.agu_i_valid = 1'b1;
      bus.agu_i_read  = rd;
      bus.agu_i_size  = sz;
      bus.agu_i_usign = us;
      bus.agu_i_rs1   = r1;
      bus.agu_i_imm   = im;
      bus.agu_i_rs2   = r2;
      bus.agu_i_itag  = tg;
   endtask

   task automatic idle_op();
      bus.agu_i_valid = 1'b0;
   endtask

   task automatic exp_cmd(input logic rd, input logic [AW-1:0] a, input logic [XLEN-1:0] wd,
                          input logic [XLEN/8-1:0] wm, input logic [ITAG_W-1:0] tg);
      cmd_t c;
      c.read = rd; c.addr = a; c.wdata = wd; c.wmask = wm; c.itag = tg;
      cq.push_back(c);
   endtask

   task automatic rsp(input logic [XLEN-1:0] d, input logic [XLEN-1:0] expv);
      bus.agu_rsp_valid = 1'b1;
      bus.agu_rsp_rdata = d;
      lq.push_back(expv);
   endtask

   task automatic rsp_off();
      bus.agu_rsp_valid = 1'b0;
   endtask

   // one load/store with a response the cycle after its handshake
   task automatic single(input logic rd, input logic [1:0] sz, input logic us,
                         input logic [XLEN-1:0] r1, input logic [XLEN-1:0] im,
                         input logic [XLEN-1:0] r2, input logic [ITAG_W-1:0] tg,
                         input logic [AW-1:0] a, input logic [XLEN-1:0] wd,
                         input logic [XLEN/8-1:0] wm,
                         input logic [XLEN-1:0] rdata, input logic [XLEN-1:0] ld);
      op(rd, sz, us, r1, im, r2, tg);
      exp_cmd(rd, a, wd, wm, tg);
      tick();
      idle_op();
      rsp(rdata, ld);
      tick();
      rsp_off();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1;
      op(1'b1, 2'b10, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
      bus.agu_cmd_ready    = 1'b1;
      bus.agu_rsp_valid    = 1'b0;
      bus.agu_rsp_rdata    = '0;
      bus.agu_o_excp_ready = 1'b0;
      #12;
      chk("rst_i_ready",   64'(bus.agu_i_ready),      64'd0);
      chk("rst_cmd_valid", 64'(bus.agu_cmd_valid),    64'd0);
      chk("rst_rsp_ready", 64'(bus.agu_rsp_ready),    64'd1);
      chk("rst_ldata",     64'(bus.agu_o_ldata),      64'd0);
      chk("rst_excp_v",    64'(bus.agu_o_excp_valid), 64'd0);
      chk("rst_excp_a",    64'(bus.agu_o_excp_addr),  64'd0);
      idle_op();
      tick();
      rst = 1'b0;
      tick();

      // lb / lbu at ea 0x103
      op(1'b1, 2'b00, 1'b0, 32'h100, 32'h3, 32'h0, 1'b1);
      #1 chk("lb_i_ready", 64'(bus.agu_i_ready), 64'd1);
      exp_cmd(1'b1, 16'h0100, 32'h0, 4'b0000, 1'b1);
      tick(); idle_op(); rsp(32'h80FF0000, 32'hFFFFFF80); tick(); rsp_off();
      single(1'b1, 2'b00, 1'b1, 32'h100, 32'h3, 32'h0, 1'b0,
             16'h0100, 32'h0, 4'b0000, 32'h80FF0000, 32'h00000080);

      // sh at 0x102, sb at 0x101 (stores give zero ldata)
      single(1'b0, 2'b01, 1'b0, 32'h100, 32'h2, 32'h1234ABCD, 1'b0,
             16'h0100, 32'hABCDABCD, 4'b1100, 32'hFFFFFFFF, 32'h0);
      single(1'b0, 2'b00, 1'b0, 32'h0FF, 32'h2, 32'h000000AB, 1'b1,
             16'h0100, 32'hABABABAB, 4'b0010, 32'h0, 32'h0);

      // lh / lhu upper half, size 11 word with address wrap above AW
      single(1'b1, 2'b01, 1'b0, 32'h300, 32'h2, 32'h0, 1'b0,
             16'h0300, 32'h0, 4'b0000, 32'h80011234, 32'hFFFF8001);
      single(1'b1, 2'b01, 1'b1, 32'h300, 32'h2, 32'h0, 1'b0,
             16'h0300, 32'h0, 4'b0000, 32'h80011234, 32'h00008001);
      single(1'b1, 2'b11, 1'b0, 32'h0001FFF0, 32'hC, 32'h0, 1'b1,
             16'hFFFC, 32'h0, 4'b0000, 32'hA5A5A5A5, 32'hA5A5A5A5);

      // back-to-back lw 0x0 / 0x4 through the PEND bypass
      op(1'b1, 2'b10, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
      exp_cmd(1'b1, 16'h0000, 32'h0, 4'b0000, 1'b0);
      tick();
      op(1'b1, 2'b10, 1'b0, 32'h4, 32'h0, 32'h0, 1'b1);
      exp_cmd(1'b1, 16'h0004, 32'h0, 4'b0000, 1'b1);
      rsp(32'hDEADBEEF, 32'hDEADBEEF);
      #1;
      chk("b2b_i_ready",   64'(bus.agu_i_ready),   64'd1);
      chk("b2b_cmd_valid", 64'(bus.agu_cmd_valid), 64'd1);
      tick();
      idle_op();
      rsp(32'hCAFEF00D, 32'hCAFEF00D);
      tick();
      rsp_off();

      // lw at ea 0x101
`ifdef AGU_MISALIGN_EXCP_EN
      begin
         exc_t x;
         x.addr = 32'h101; x.itag = 1'b1; x.store = 1'b0;
         op(1'b1, 2'b10, 1'b0, 32'h100, 32'h1, 32'h0, 1'b1);
         xq.push_back(x);
         #1;
         chk("mis_i_ready",   64'(bus.agu_i_ready),   64'd1);
         chk("mis_cmd_valid", 64'(bus.agu_cmd_valid), 64'd0);
         tick();
         op(1'b1, 2'b10, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
         for (int i = 0; i < 3; i++) begin
            #1;
            chk("excp_i_ready",   64'(bus.agu_i_ready),   64'd0);
            chk("excp_cmd_valid", 64'(bus.agu_cmd_valid), 64'd0);
            tick();
         end
         idle_op();
         bus.agu_o_excp_ready = 1'b1;
         tick();
         bus.agu_o_excp_ready = 1'b0;
         #1 chk("excp_cleared", 64'(bus.agu_o_excp_valid), 64'd0);
         tick();
      end
`else
      single(1'b1, 2'b10, 1'b0, 32'h100, 32'h1, 32'h0, 1'b1,
             16'h0100, 32'h0, 4'b0000, 32'h11223344, 32'h11223344);
`endif

      // sw stalled by cmd_ready low for 4 cycles
      op(1'b0, 2'b10, 1'b0, 32'h200, 32'h8, 32'h55667788, 1'b0);
      bus.agu_cmd_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("stall_i_ready",   64'(bus.agu_i_ready),   64'd0);
         chk("stall_cmd_valid", 64'(bus.agu_cmd_valid), 64'd1);
         chk("stall_cmd_addr",  64'(bus.agu_cmd_addr),  64'h208);
         chk("stall_cmd_wdata", 64'(bus.agu_cmd_wdata), 64'h55667788);
         chk("stall_cmd_wmask", 64'(bus.agu_cmd_wmask), 64'hF);
         tick();
      end
      exp_cmd(1'b0, 16'h0208, 32'h55667788, 4'b1111, 1'b0);
      bus.agu_cmd_ready = 1'b1;
      #1 chk("stall_release", 64'(bus.agu_i_ready), 64'd1);
      tick();
      idle_op();
      rsp(32'h0, 32'h0);
      tick();
      rsp_off();

      // reset while PEND; the late response must be ignored
      op(1'b1, 2'b10, 1'b0, 32'h40, 32'h0, 32'h0, 1'b0);
      exp_cmd(1'b1, 16'h0040, 32'h0, 4'b0000, 1'b0);
      tick();
      idle_op();
      rst = 1'b1;
      #1;
      chk("pend_rst_i_ready",   64'(bus.agu_i_ready),   64'd0);
      chk("pend_rst_cmd_valid", 64'(bus.agu_cmd_valid), 64'd0);
      tick();
      rst = 1'b0;
      rsp(32'h12345678, 32'h0);
      #1 chk("pend_rst_ldata", 64'(bus.agu_o_ldata), 64'd0);
      tick();
      rsp_off();
      single(1'b1, 2'b00, 1'b1, 32'h40, 32'h1, 32'h0, 1'b1,
             16'h0040, 32'h0, 4'b0000, 32'h00005A00, 32'h0000005A);

      tick();
      tick();
      chk("cmd_queue_drained",   64'(cq.size()), 64'd0);
      chk("ldata_queue_drained", 64'(lq.size()), 64'd0);
      chk("excp_queue_drained",  64'(xq.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule
